// File: rtl/hdl_top_uart.sv
// SSP-attached UART: 16-deep TX/RX FIFOs, 8N1 framing, RS-232/RS-485 pins.
// Define SSP_UART_RTO_EN to build the receive-timeout (RTO) logic.
module hdl_top_uart (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        SSP_SSEL,
    input  logic        SSP_En,
    input  logic        SSP_EOC,
    input  logic [2:0]  SSP_RA,
    input  logic        SSP_WnR,
    input  logic [11:0] SSP_DI,
    output logic [11:0] SSP_DO,
    input  logic        RxD_232,
    input  logic        RxD_485,
    output logic        TxD_232,
    output logic        TxD_485,
    input  logic        xCTS,
    output logic        xRTS,
    output logic        xDE,
    output logic        IRQ
);
    logic [11:0] r_ucr, r_spr, r_do;
    logic [7:0]  r_tf_mem [16];
    logic [7:0]  r_rf_mem [16];
    logic [3:0]  r_tf_wp, r_tf_rp, r_rf_wp, r_rf_rp;
    logic [4:0]  r_tf_cnt, r_rf_cnt;
    logic        r_tbusy, r_rbusy;
    logic [9:0]  r_tsr;
    logic [7:0]  r_rsr;
    logic [11:0] r_tcnt, r_rcnt;
    logic [3:0]  r_tbit, r_rbit;
    logic        r_rx_m, r_rx_q, r_rx_p;

    logic w_acc, w_wr, w_rd, w_tfc, w_rfc, w_rdr_rd;
    logic w_tf_ne, w_tf_hf, w_tf_ff, w_rf_ne, w_rf_hf, w_rf_ff;
    logic w_tf_push, w_tx_load, w_rf_push, w_rf_pop;
    logic w_rmid, w_rx_done, w_rto;
    logic w_ithe, w_itfe, w_irhf, w_irto;
    logic [11:0] w_usr, w_rdata;

    assign w_acc    = SSP_SSEL & SSP_En & SSP_EOC;
    assign w_wr     = w_acc & SSP_WnR;
    assign w_rd     = w_acc & ~SSP_WnR;
    assign w_tfc    = w_wr & (SSP_RA == 3'd0) & SSP_DI[0];
    assign w_rfc    = w_wr & (SSP_RA == 3'd0) & SSP_DI[1];
    assign w_rdr_rd = w_rd & (SSP_RA == 3'd3);

    assign w_tf_ne = |r_tf_cnt;
    assign w_tf_hf = r_tf_cnt >= 5'd8;
    assign w_tf_ff = r_tf_cnt[4];
    assign w_rf_ne = |r_rf_cnt;
    assign w_rf_hf = r_rf_cnt >= 5'd8;
    assign w_rf_ff = r_rf_cnt[4];

    assign w_tf_push = w_wr & (SSP_RA == 3'd2) & ~w_tf_ff;
    assign w_tx_load = ~r_tbusy & w_tf_ne & ~xCTS;
    assign w_rf_pop  = w_rdr_rd & w_rf_ne;
    assign w_rf_push = w_rx_done & ~w_rf_ff;

    assign w_ithe = r_ucr[2] & (r_tf_cnt <= 5'd8);
    assign w_itfe = r_ucr[3] & ~w_tf_ne & ~r_tbusy;
    assign w_irhf = r_ucr[4] & w_rf_hf;
    assign w_irto = r_ucr[5] & w_rto;
    assign IRQ    = w_ithe | w_itfe | w_irhf | w_irto;

    assign w_usr = {1'b0, w_irto, w_irhf, w_itfe, w_ithe, w_rto,
                    w_rf_ff, w_rf_hf, w_rf_ne, w_tf_ff, w_tf_hf, w_tf_ne};

    always_comb begin
        w_rdata = 12'h000;
        case (SSP_RA)
            3'd0: w_rdata = r_ucr;
            3'd1: w_rdata = w_usr;
            3'd3: if (w_rf_ne) w_rdata = {4'h0, r_rf_mem[r_rf_rp]};
            3'd4: w_rdata = r_spr;
            default: w_rdata = 12'h000;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_ucr <= 12'h000;
            r_spr <= 12'h000;
            r_do  <= 12'h000;
        end else begin
            if (w_wr && SSP_RA == 3'd0) r_ucr <= {SSP_DI[11:2], 2'b00};
            if (w_wr && SSP_RA == 3'd4) r_spr <= SSP_DI;
            if (w_rd) r_do <= w_rdata;
        end
    end

    assign SSP_DO = r_do;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_tf_wp  <= 4'd0;
            r_tf_rp  <= 4'd0;
            r_tf_cnt <= 5'd0;
        end else if (w_tfc) begin
            r_tf_wp  <= 4'd0;
            r_tf_rp  <= 4'd0;
            r_tf_cnt <= 5'd0;
        end else begin
            if (w_tf_push) r_tf_wp <= r_tf_wp + 4'd1;
            if (w_tx_load) r_tf_rp <= r_tf_rp + 4'd1;
            r_tf_cnt <= r_tf_cnt + {4'd0, w_tf_push} - {4'd0, w_tx_load};
        end
    end

    always_ff @(posedge Clk) begin
        if (w_tf_push) r_tf_mem[r_tf_wp] <= SSP_DI[7:0];
        if (w_rf_push) r_rf_mem[r_rf_wp] <= r_rsr;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rf_wp  <= 4'd0;
            r_rf_rp  <= 4'd0;
            r_rf_cnt <= 5'd0;
        end else if (w_rfc) begin
            r_rf_wp  <= 4'd0;
            r_rf_rp  <= 4'd0;
            r_rf_cnt <= 5'd0;
        end else begin
            if (w_rf_push) r_rf_wp <= r_rf_wp + 4'd1;
            if (w_rf_pop) r_rf_rp <= r_rf_rp + 4'd1;
            r_rf_cnt <= r_rf_cnt + {4'd0, w_rf_push} - {4'd0, w_rf_pop};
        end
    end

    // Transmitter: 10-bit frame shifted out LSB first, stop bit refills with 1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_tbusy <= 1'b0;
            r_tsr   <= 10'd0;
            r_tcnt  <= 12'd0;
            r_tbit  <= 4'd0;
        end else if (w_tx_load) begin
            r_tbusy <= 1'b1;
            r_tsr   <= {1'b1, r_tf_mem[r_tf_rp], 1'b0};
            r_tcnt  <= 12'd0;
            r_tbit  <= 4'd0;
        end else if (r_tbusy) begin
            if (r_tcnt >= r_spr) begin
                r_tcnt <= 12'd0;
                r_tsr  <= {1'b1, r_tsr[9:1]};
                r_tbit <= r_tbit + 4'd1;
                if (r_tbit == 4'd9) r_tbusy <= 1'b0;
            end else begin
                r_tcnt <= r_tcnt + 12'd1;
            end
        end
    end

    assign TxD_232 = ~r_tbusy | r_tsr[0];
    assign TxD_485 = TxD_232;
    assign xDE     = r_tbusy;
    assign xRTS    = w_rf_ff;

    assign w_rmid    = r_rbusy & (r_rcnt == {1'b0, r_spr[11:1]});
    assign w_rx_done = w_rmid & (r_rbit == 4'd9) & r_rx_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rx_m  <= 1'b0;
            r_rx_q  <= 1'b0;
            r_rx_p  <= 1'b0;
            r_rbusy <= 1'b0;
            r_rcnt  <= 12'd0;
            r_rbit  <= 4'd0;
            r_rsr   <= 8'd0;
        end else begin
            r_rx_m <= r_ucr[6] ? RxD_485 : RxD_232;
            r_rx_q <= r_rx_m;
            r_rx_p <= r_rx_q;
            if (!r_rbusy) begin
                if (r_rx_p && !r_rx_q) begin
                    r_rbusy <= 1'b1;
                    r_rcnt  <= 12'd0;
                    r_rbit  <= 4'd0;
                end
            end else begin
                if (r_rcnt >= r_spr) begin
                    r_rcnt <= 12'd0;
                    r_rbit <= r_rbit + 4'd1;
                end else begin
                    r_rcnt <= r_rcnt + 12'd1;
                end
                // A start bit that reads 1 at mid-bit was a glitch.
                if (w_rmid) begin
                    if (r_rbit == 4'd0 && r_rx_q) r_rbusy <= 1'b0;
                    else if (r_rbit == 4'd9) r_rbusy <= 1'b0;
                    else if (r_rbit != 4'd0) r_rsr <= {r_rx_q, r_rsr[7:1]};
                end
            end
        end
    end

`ifdef SSP_UART_RTO_EN
    logic        r_rto;
    logic [11:0] r_rto_bc;
    logic [5:0]  r_rto_bits;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_rto      <= 1'b0;
            r_rto_bc   <= 12'd0;
            r_rto_bits <= 6'd0;
        end else begin
            if (w_rfc || w_rdr_rd) r_rto <= 1'b0;
            else if (r_rto_bits == 6'd40) r_rto <= 1'b1;
            if (w_rfc || w_rdr_rd || w_rf_push || !w_rf_ne) begin
                r_rto_bc   <= 12'd0;
                r_rto_bits <= 6'd0;
            end else if (r_rto_bits != 6'd40) begin
                if (r_rto_bc >= r_spr) begin
                    r_rto_bc   <= 12'd0;
                    r_rto_bits <= r_rto_bits + 6'd1;
                end else begin
                    r_rto_bc <= r_rto_bc + 12'd1;
                end
            end
        end
    end

    assign w_rto = r_rto;
`else
    assign w_rto = 1'b0;
`endif

endmodule

// File: tb/tb_hdl_top_uart.sv
// Directed bench for hdl_top_uart with TxD_232 looped back to RxD_232.
module tb_hdl_top_uart;
    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        SSP_SSEL = 1'b0;
    logic        SSP_En = 1'b0;
    logic        SSP_EOC = 1'b0;
    logic [2:0]  SSP_RA = 3'd0;
    logic        SSP_WnR = 1'b0;
    logic [11:0] SSP_DI = 12'h000;
    logic [11:0] SSP_DO;
    logic        RxD_232, RxD_485;
    logic        TxD_232, TxD_485;
    logic        xCTS = 1'b1;
    logic        xRTS, xDE, IRQ;
    logic        r_rx485 = 1'b1;

    int n_chk = 0;
    int n_err = 0;
    logic [11:0] rd;
    logic [7:0]  pat [8] = '{8'h01, 8'h80, 8'hA5, 8'h5A,
                             8'hFF, 8'h00, 8'h3C, 8'hC3};

    assign RxD_232 = TxD_232;
    assign RxD_485 = r_rx485;

    always #5 Clk = ~Clk;

    hdl_top_uart dut (
        .Clk(Clk), .Rst(Rst),
        .SSP_SSEL(SSP_SSEL), .SSP_En(SSP_En), .SSP_EOC(SSP_EOC),
        .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
        .SSP_DI(SSP_DI), .SSP_DO(SSP_DO),
        .RxD_232(RxD_232), .RxD_485(RxD_485),
        .TxD_232(TxD_232), .TxD_485(TxD_485),
        .xCTS(xCTS), .xRTS(xRTS), .xDE(xDE), .IRQ(IRQ)
    );

    task automatic check(input string tag, input logic [11:0] got,
                         input logic [11:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] ra, input logic [11:0] d);
        @(negedge Clk);
        SSP_SSEL = 1'b1; SSP_En = 1'b1; SSP_EOC = 1'b1;
        SSP_WnR = 1'b1; SSP_RA = ra; SSP_DI = d;
        @(negedge Clk);
        SSP_SSEL = 1'b0; SSP_En = 1'b0; SSP_EOC = 1'b0; SSP_WnR = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] ra, output logic [11:0] d);
        @(negedge Clk);
        SSP_SSEL = 1'b1; SSP_En = 1'b1; SSP_EOC = 1'b1;
        SSP_WnR = 1'b0; SSP_RA = ra;
        @(negedge Clk);
        d = SSP_DO;
        SSP_SSEL = 1'b0; SSP_En = 1'b0; SSP_EOC = 1'b0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge Clk);
    endtask

    initial begin
        wait_clk(3);
        check("rst_do", SSP_DO, 12'h000);
        check("rst_txd", {10'd0, TxD_232, TxD_485}, 12'h003);
        check("rst_de_irq_rts", {9'd0, xDE, IRQ, xRTS}, 12'h000);
        Rst = 1'b1;
        for (int a = 0; a < 6; a++) begin
            bus_rd(3'(a), rd);
            check($sformatf("rst_reg%0d", a), rd, 12'h000);
        end

        bus_wr(3'd0, 12'h7C0);
        bus_rd(3'd0, rd);
        check("ucr_rw", rd, 12'h7C0);
        bus_wr(3'd4, 12'hA5A);
        bus_rd(3'd4, rd);
        check("spr_rw", rd, 12'hA5A);
        bus_wr(3'd5, 12'hFFF);
        bus_rd(3'd5, rd);
        check("addr5", rd, 12'h000);
        bus_wr(3'd0, 12'h000);
        bus_wr(3'd4, 12'h003);

        xCTS = 1'b1;
        for (int i = 0; i < 17; i++) bus_wr(3'd2, 12'(i));
        bus_rd(3'd1, rd);
        check("tf_full", rd, 12'h007);
        bus_rd(3'd2, rd);
        check("tdr_rd", rd, 12'h000);
        bus_wr(3'd0, 12'h001);
        bus_rd(3'd1, rd);
        check("tf_clear", rd, 12'h000);
        bus_rd(3'd0, rd);
        check("tfc_selfclr", rd, 12'h000);

        xCTS = 1'b0;
        bus_wr(3'd2, 12'h055);
        wait_clk(10);
        check("tx_de", {11'd0, xDE}, 12'h001);
        bus_rd(3'd1, rd);
        check("lb_not_yet", rd & 12'h008, 12'h000);
        wait_clk(50);
        bus_rd(3'd1, rd);
        check("lb_usr", rd, 12'h008);
        bus_rd(3'd3, rd);
        check("lb_rdr", rd, 12'h055);
        bus_rd(3'd1, rd);
        check("lb_empty", rd, 12'h000);
        bus_rd(3'd3, rd);
        check("rdr_empty", rd, 12'h000);

        bus_wr(3'd0, 12'h004);
        check("irq_the", {11'd0, IRQ}, 12'h001);
        bus_rd(3'd1, rd);
        check("usr_the", rd, 12'h080);
        bus_wr(3'd0, 12'h000);
        check("irq_off", {11'd0, IRQ}, 12'h000);

        bus_wr(3'd0, 12'h010);
        for (int i = 0; i < 8; i++) bus_wr(3'd2, {4'h0, pat[i]});
        wait_clk(420);
        bus_rd(3'd1, rd);
        check("rhf_usr", rd, 12'h218);
        check("rhf_irq", {11'd0, IRQ}, 12'h001);
        for (int i = 0; i < 8; i++) begin
            bus_rd(3'd3, rd);
            check($sformatf("rx_byte%0d", i), rd, {4'h0, pat[i]});
        end
        check("rhf_irq_off", {11'd0, IRQ}, 12'h000);

        bus_wr(3'd0, 12'h040);
        bus_wr(3'd2, 12'h099);
        wait_clk(60);
        bus_rd(3'd1, rd);
        check("md485_usr", rd, 12'h000);
        bus_wr(3'd0, 12'h000);

        bus_wr(3'd2, 12'h011);
        bus_wr(3'd2, 12'h022);
        wait_clk(100);
        bus_rd(3'd1, rd);
        check("rfc_before", rd, 12'h008);
        bus_wr(3'd0, 12'h002);
        bus_rd(3'd1, rd);
        check("rfc_after", rd, 12'h000);

        bus_wr(3'd0, 12'h020);
        bus_wr(3'd2, 12'h03C);
        wait_clk(260);
        bus_rd(3'd1, rd);
`ifdef SSP_UART_RTO_EN
        check("rto_usr", rd, 12'h448);
        check("rto_irq", {11'd0, IRQ}, 12'h001);
`else
        check("rto_usr", rd, 12'h008);
        check("rto_irq", {11'd0, IRQ}, 12'h000);
`endif
        bus_rd(3'd3, rd);
        check("rto_rdr", rd, 12'h03C);
        bus_rd(3'd1, rd);
        check("rto_clr", rd, 12'h000);
        bus_wr(3'd0, 12'h000);

        bus_wr(3'd2, 12'h0F0);
        wait_clk(10);
        check("mid_de", {11'd0, xDE}, 12'h001);
        Rst = 1'b0;
        #1;
        check("mid_rst_pins", {9'd0, TxD_232, TxD_485, xDE}, 12'h006);
        check("mid_rst_do", SSP_DO, 12'h000);
        wait_clk(2);
        Rst = 1'b1;
        for (int a = 0; a < 5; a++) begin
            bus_rd(3'(a), rd);
            check($sformatf("post_rst%0d", a), rd, 12'h000);
        end
        wait_clk(60);
        bus_rd(3'd1, rd);
        check("post_rst_quiet", rd, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
